// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single main-memory port between the CPU memory
// cycle (mreq_n / r_w_n / ack) and a DMA requester. Each access runs a
// fixed-latency memory cycle, then returns a one-cycle ack to the winner.
// CPU has priority. Define ARB_STARVE_GUARD_EN to add a DMA starvation guard
// that forces a DMA win after STARVE_LIMIT pending cycles.
//
// state  | meaning
// IDLE   | arbitrate; latch winner's addr/wdata/we; load wait counter
// ACCESS | mem_en high, mem_* stable; counter runs down to 0
// DONE   | one-cycle ack to the owner; back to IDLE
module mem_bus_arbiter #(
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        cpu_mreq_n,
  input  logic        cpu_r_w_n,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        owner_dma,
  output logic        starve_flag
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_param_check
    $error("mem_bus_arbiter: WAIT_CYCLES or STARVE_LIMIT out of range");
  end

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       cpu_req;
  logic       promote;
  logic       grant_cpu;
  logic       grant_dma;
  logic       last_access;

  assign cpu_req     = ~cpu_mreq_n;
  // an armed starvation guard only matters while DMA is actually asking
  assign promote     = starve_flag & dma_req;
  assign grant_cpu   = (state == IDLE) & cpu_req & ~promote;
  assign grant_dma   = (state == IDLE) & dma_req & (promote | ~cpu_req);
  assign last_access = (state == ACCESS) & (wait_cnt == 4'd0);

  assign mem_en  = (state == ACCESS);
  assign cpu_ack = (state == DONE) & ~owner_dma;
  assign dma_ack = (state == DONE) &  owner_dma;

  // state and wait-counter registers
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // next-state and wait-counter update
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (grant_cpu || grant_dma) begin
          state_nxt = ACCESS;
          wait_nxt  = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) state_nxt = DONE;
        else                  wait_nxt  = wait_cnt - 4'd1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch the winner's request at grant; capture read data on the last access cycle
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      owner_dma <= 1'b0;
      rdata     <= 16'h0000;
    end else begin
      if (grant_cpu) begin
        mem_we    <= ~cpu_r_w_n;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        owner_dma <= 1'b0;
      end else if (grant_dma) begin
        mem_we    <= dma_we;
        mem_addr  <= dma_addr;
        mem_wdata <= dma_wdata;
        owner_dma <= 1'b1;
      end
      if (last_access && !mem_we) rdata <= mem_rdata;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  assign starve_flag = (starve_cnt == STARVE_MAX);

  // count cycles DMA waits while not being served; saturate at the limit
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      starve_cnt <= 8'd0;
    end else if (!dma_req || grant_dma) begin
      starve_cnt <= 8'd0;
    end else if (!(owner_dma && state != IDLE) && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign starve_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: table-driven single transactions, hand-written
// multi-cycle sequences, then randomized traffic against a cycle-number model.
module tb_mem_bus_arbiter;

  localparam int W   = 2;
  localparam int LIM = 3;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_r_w_n = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_wdata = 16'h0000;
  logic        cpu_ack;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [15:0] dma_addr = 16'h0000;
  logic [15:0] dma_wdata = 16'h0000;
  logic        dma_ack;
  logic [15:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        owner_dma;
  logic        starve_flag;

  mem_bus_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .RESET_N(RESET_N),
    .cpu_mreq_n(cpu_mreq_n), .cpu_r_w_n(cpu_r_w_n), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner_dma(owner_dma), .starve_flag(starve_flag)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the cycle index of the last grant. A transaction
  // granted in cycle g occupies the bus for g+1..g+W, acks in g+W+1 and the
  // arbiter is free again from g+W+2.
  int          m_cyc = 0;
  int          m_g = -1;
  int          m_starve = 0;
  bit          m_dma = 1'b0;
  bit          m_we = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [15:0] m_wdata = 16'h0000;
  logic [15:0] m_rdata = 16'h0000;
  bit          m_idle, m_busy_dma, m_promote;

  always @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      m_cyc = 0; m_g = -1; m_starve = 0; m_dma = 1'b0; m_we = 1'b0;
      m_addr = 16'h0000; m_wdata = 16'h0000; m_rdata = 16'h0000;
    end else begin
      m_idle     = (m_g < 0) || (m_cyc >= m_g + W + 2);
      m_busy_dma = !m_idle && m_dma;
      m_promote  = GUARD && (m_starve == LIM) && dma_req;
      if (!m_idle && m_cyc == m_g + W && !m_we) m_rdata = mem_rdata;
      if (m_idle && !cpu_mreq_n && !m_promote) begin
        m_dma = 1'b0; m_we = !cpu_r_w_n; m_addr = cpu_addr; m_wdata = cpu_wdata; m_g = m_cyc;
      end else if (m_idle && dma_req) begin
        m_dma = 1'b1; m_we = dma_we; m_addr = dma_addr; m_wdata = dma_wdata; m_g = m_cyc;
      end
      if (!GUARD || !dma_req || (m_idle && m_dma && m_g == m_cyc)) m_starve = 0;
      else if (!m_busy_dma && m_starve < LIM) m_starve++;
      m_cyc++;
    end
  end

  typedef struct {
    logic        cpu;
    logic        rwn;
    logic [15:0] caddr;
    logic [15:0] cwdata;
    logic        dma;
    logic        dwe;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic [15:0] mrd;
    logic        e_dma;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  int   cpu_at, dma_at, nc, nd, en_cnt, ack1, ack2;
  logic fl[1:12];
  logic own5;
  logic exp_en, exp_ack, exp_flag;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2000, 16'h1234, 16'h5555, 1'b1, 1'b1, 16'h2000, 16'h1234, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h00FF, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h6666, 1'b0, 1'b1, 16'h00FF, 16'hA5A5, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h3FFE, 16'h9999, 16'hCAFE, 1'b1, 1'b0, 16'h3FFE, 16'h9999, 16'hCAFE};
    vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 16'h4242, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h0001, 1'b0, 1'b0, 16'hFFFF, 16'h4242, 16'h0001};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset acks", {cpu_ack, dma_ack}, 0);
    chk("reset ctl", {mem_en, mem_we, owner_dma, starve_flag}, 0);
    chk("reset addr", mem_addr, 0);
    chk("reset wdata", mem_wdata, 0);
    chk("reset rdata", rdata, 0);
    RESET_N = 1'b1;

    // single transactions from IDLE
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      cpu_mreq_n = ~v.cpu; cpu_r_w_n = v.rwn; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
      dma_req = v.dma; dma_we = v.dwe; dma_addr = v.daddr; dma_wdata = v.dwdata;
      mem_rdata = ~v.mrd;
      for (int k = 1; k <= W; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d access%0d ctl", i, k), {mem_en, mem_we, owner_dma, cpu_ack, dma_ack},
            {1'b1, v.e_we, v.e_dma, 1'b0, 1'b0});
        chk($sformatf("v%0d access%0d data", i, k), {mem_addr, mem_wdata}, {v.e_addr, v.e_wdata});
        cpu_addr = ~v.caddr; cpu_wdata = ~v.cwdata; dma_addr = ~v.daddr; dma_wdata = ~v.dwdata;
        mem_rdata = (k == W) ? v.mrd : ~v.mrd;
      end
      @(negedge clk);
      chk($sformatf("v%0d done acks", i), {cpu_ack, dma_ack, mem_en, owner_dma},
          {~v.e_dma, v.e_dma, 1'b0, v.e_dma});
      chk($sformatf("v%0d rdata", i), rdata, v.e_rdata);
      cpu_mreq_n = 1'b1; dma_req = 1'b0; mem_rdata = 16'h7E7E;
      @(negedge clk);
      chk($sformatf("v%0d idle", i), {cpu_ack, dma_ack, mem_en}, 0);
      chk($sformatf("v%0d held addr", i), {mem_addr, mem_we}, {v.e_addr, v.e_we});
    end

    // simultaneous requests: CPU first, DMA right after, acks W+2 apart
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b1; cpu_addr = 16'h0400;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0800; dma_wdata = 16'h7777;
    cpu_at = -1; dma_at = -1; nc = 0; nd = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (cpu_ack) begin nc++; cpu_at = c; cpu_mreq_n = 1'b1; end
      if (dma_ack) begin nd++; dma_at = c; dma_req = 1'b0; end
    end
    chk("simul cpu ack cycle", cpu_at, W + 1);
    chk("simul dma ack cycle", dma_at, 2 * W + 3);
    chk("simul ack counts", {nc[7:0], nd[7:0]}, {8'd1, 8'd1});

    // back-to-back CPU reads with the request held through the ack
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b1; cpu_addr = 16'h0500; mem_rdata = 16'h0BAD;
    ack1 = -1; ack2 = -1; nc = 0; nd = 0; en_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      en_cnt += int'(mem_en);
      if (dma_ack) nd++;
      if (cpu_ack) begin
        nc++;
        if (nc == 1) ack1 = c;
        else begin ack2 = c; cpu_mreq_n = 1'b1; end
      end
    end
    chk("b2b first ack", ack1, W + 1);
    chk("b2b second ack", ack2, 2 * W + 3);
    chk("b2b mem_en cycles", en_cnt, 2 * W);
    chk("b2b no dma ack", nd, 0);
    chk("b2b rdata", rdata, 16'h0BAD);

    // reset asserted in the middle of an ACCESS cycle
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b1; cpu_addr = 16'h0100; mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("rst pre en", mem_en, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst async ctl", {mem_en, cpu_ack, dma_ack, owner_dma, mem_we}, 0);
    chk("rst async data", {rdata, mem_addr}, 0);
    cpu_mreq_n = 1'b1;
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    nc = 0; en_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      nc += int'(cpu_ack) + int'(dma_ack);
      en_cnt += int'(mem_en);
    end
    chk("rst no stale ack", nc, 0);
    chk("rst stays idle", en_cnt, 0);

    // CPU hogging the bus while DMA waits
    cpu_mreq_n = 1'b0; cpu_r_w_n = 1'b1; cpu_addr = 16'h0600;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0700; mem_rdata = 16'h1357;
    dma_at = -1; own5 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      fl[c] = starve_flag;
      if (c == W + 3) own5 = owner_dma;
      if (dma_ack) begin dma_at = c; dma_req = 1'b0; end
    end
    cpu_mreq_n = 1'b1; dma_req = 1'b0;
    chk("starve flag before limit", fl[W], 0);
    chk("starve flag at limit", fl[W + 1], GUARD);
    chk("starve next grant owner", own5, GUARD);
    chk("starve flag after grant", fl[W + 3], 0);
    chk("starve dma ack cycle", dma_at, GUARD ? 2 * W + 3 : -1);
    repeat (3) @(negedge clk);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      exp_en   = (m_g >= 0) && (m_cyc > m_g) && (m_cyc <= m_g + W);
      exp_ack  = (m_g >= 0) && (m_cyc == m_g + W + 1);
      exp_flag = GUARD && (m_starve == LIM);
      chk($sformatf("random c%0d", c),
          {cpu_ack, dma_ack, mem_en, mem_we, owner_dma, starve_flag, mem_addr, mem_wdata, rdata},
          {exp_ack & ~m_dma, exp_ack & m_dma, exp_en, m_we, m_dma, exp_flag, m_addr, m_wdata, m_rdata});
      cpu_mreq_n = ($urandom_range(0, 2) == 0);
      cpu_r_w_n  = 1'($urandom_range(0, 1));
      cpu_addr   = 16'($urandom);
      cpu_wdata  = 16'($urandom);
      dma_req    = ($urandom_range(0, 3) != 0);
      dma_we     = 1'($urandom_range(0, 1));
      dma_addr   = 16'($urandom);
      dma_wdata  = 16'($urandom);
      mem_rdata  = 16'($urandom);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
